rv32c_compressor: RTL and testbench

//   Streaming RV32I->RV32C compressor: the encode side of the compressed-ISA decoders in the

---
 rtl/rv32c_compressor.sv | 110 +++++++++++
 tb/tb_rv32c_compressor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rv32c_compressor.sv
// rv32c_compressor: streams RV32I instructions, rewrites compressible ones as RV32C and packs halfwords into fetch words.
// Define RV32C_COMPRESS_LDST_EN to also compress lw/sw into c.lw/c.sw.
module rv32c_compressor #(
  parameter int CNT_W = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic [31:0]      iINSTR,
  input  logic             iFLUSH,
  output logic             oVALID,
  input  logic             iREADY,
  output logic [31:0]      oWORD,
  output logic             oPENDING,
  output logic [CNT_W-1:0] oSAVED
);
  typedef enum logic {EMPTY, HALF} state_t;
  state_t r_state, w_state;
  logic [15:0] r_residue, w_residue, w_c16, w_ldst;
  logic [31:0] r_word, w_word;
  logic [CNT_W-1:0] r_saved;
  logic r_valid, w_valid, w_accept, w_is_c;
  logic [6:0] w_op, w_f7;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic [2:0] w_f3;
  logic [11:0] w_imm;
  logic w_is_addi, w_is_add, w_imm_small, w_rd_p;
  logic w_addi4spn, w_li, w_caddi, w_mv, w_cadd, w_lw, w_sw;
  assign w_op = iINSTR[6:0];
  assign w_rd = iINSTR[11:7];
  assign w_f3 = iINSTR[14:12];
  assign w_rs1 = iINSTR[19:15];
  assign w_rs2 = iINSTR[24:20];
  assign w_f7 = iINSTR[31:25];
  assign w_imm = iINSTR[31:20];
  assign w_is_addi = w_op == 7'h13 && w_f3 == 3'b000;
  assign w_is_add = w_op == 7'h33 && w_f3 == 3'b000 && w_f7 == 7'd0;
  assign w_imm_small = &w_imm[11:5] | ~|w_imm[11:5];
  assign w_rd_p = w_rd[4:3] == 2'b01;
  assign w_addi4spn = w_is_addi && w_rs1 == 5'd2 && w_rd_p && w_imm != 12'd0 &&
                      w_imm[1:0] == 2'b00 && w_imm[11:10] == 2'b00;
  assign w_li = w_is_addi && w_rs1 == 5'd0 && w_rd != 5'd0 && w_imm_small;
  assign w_caddi = w_is_addi && w_rs1 == w_rd && w_rd != 5'd0 && w_imm != 12'd0 && w_imm_small;
  assign w_mv = w_is_add && w_rs1 == 5'd0 && w_rd != 5'd0 && w_rs2 != 5'd0;
  assign w_cadd = w_is_add && w_rs1 == w_rd && w_rd != 5'd0 && w_rs2 != 5'd0;
`ifdef RV32C_COMPRESS_LDST_EN
  logic [11:0] w_soff;
  assign w_soff = {iINSTR[31:25], iINSTR[11:7]};
  assign w_lw = w_op == 7'h03 && w_f3 == 3'b010 && w_rd_p && w_rs1[4:3] == 2'b01 &&
                w_imm[1:0] == 2'b00 && w_imm[11:7] == 5'd0;
  assign w_sw = w_op == 7'h23 && w_f3 == 3'b010 && w_rs1[4:3] == 2'b01 && w_rs2[4:3] == 2'b01 &&
                w_soff[1:0] == 2'b00 && w_soff[11:7] == 5'd0;
  assign w_ldst = w_lw ? {3'b010, w_imm[5:3], w_rs1[2:0], w_imm[2], w_imm[6], w_rd[2:0], 2'b00}
                       : {3'b110, w_soff[5:3], w_rs1[2:0], w_soff[2], w_soff[6], w_rs2[2:0], 2'b00};
`else
  assign w_lw = 1'b0;
  assign w_sw = 1'b0;
  assign w_ldst = 16'd0;
`endif
  assign w_c16 = w_addi4spn ? {3'b000, w_imm[5:4], w_imm[9:6], w_imm[2], w_imm[3], w_rd[2:0], 2'b00} :
                 w_li       ? {3'b010, w_imm[5], w_rd, w_imm[4:0], 2'b01} :
                 w_caddi    ? {3'b000, w_imm[5], w_rd, w_imm[4:0], 2'b01} :
                 (w_lw | w_sw) ? w_ldst :
                 w_mv       ? {4'b1000, w_rd, w_rs2, 2'b10} :
                              {4'b1001, w_rd, w_rs2, 2'b10};
  assign w_is_c = w_addi4spn | w_li | w_caddi | w_lw | w_sw | w_mv | w_cadd;
  assign oREADY = ~r_valid | iREADY;
  assign w_accept = iVALID & oREADY;
  assign oVALID = r_valid;
  assign oWORD = r_word;
  assign oPENDING = r_state == HALF;
  assign oSAVED = r_saved;
  always_comb begin
    w_state = r_state;
    w_residue = r_residue;
    w_word = r_word;
    w_valid = r_valid & ~iREADY;
    if (w_accept && r_state == EMPTY) begin
      w_state = w_is_c ? HALF : EMPTY;
      w_residue = w_is_c ? w_c16 : r_residue;
      w_word = w_is_c ? r_word : iINSTR;
      w_valid = w_is_c ? w_valid : 1'b1;
    end else if (w_accept) begin
      w_state = w_is_c ? EMPTY : HALF;
      w_residue = w_is_c ? r_residue : iINSTR[31:16];
      w_word = {w_is_c ? w_c16 : iINSTR[15:0], r_residue};
      w_valid = 1'b1;
    end else if (iFLUSH && r_state == HALF && oREADY) begin
      w_state = EMPTY;
      w_word = {16'h0001, r_residue};
      w_valid = 1'b1;
    end
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= EMPTY;
      r_residue <= 16'd0;
      r_word <= 32'd0;
      r_valid <= 1'b0;
      r_saved <= '0;
    end else begin
      r_state <= w_state;
      r_residue <= w_residue;
      r_word <= w_word;
      r_valid <= w_valid;
      if (w_accept && w_is_c && ~&r_saved) r_saved <= r_saved + 1'b1;
    end
  end
endmodule

// File: tb/tb_rv32c_compressor.sv
// tb_rv32c_compressor: directed and randomized checks against a halfword-queue reference model.
module tb_rv32c_compressor;
  localparam int CNT_W = 4;
  localparam int SAT = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic iRST = 1'b0, iVALID = 1'b0, iFLUSH = 1'b0, iREADY = 1'b1;
  logic [31:0] iINSTR = 32'd0;
  logic oREADY, oVALID, oPENDING;
  logic [31:0] oWORD;
  logic [CNT_W-1:0] oSAVED;
  int n_vec = 0, n_err = 0, m_saved = 0;
  logic [15:0] hq[$];
  logic [31:0] wq[$];
  always #5 clk = ~clk;
  rv32c_compressor #(.CNT_W(CNT_W)) dut (
    .iCLK(clk), .iRST(iRST), .iVALID(iVALID), .oREADY(oREADY), .iINSTR(iINSTR),
    .iFLUSH(iFLUSH), .oVALID(oVALID), .iREADY(iREADY), .oWORD(oWORD),
    .oPENDING(oPENDING), .oSAVED(oSAVED)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  function automatic bit ref_c16(input logic [31:0] in, output logic [15:0] c);
    int op, f3, f7, rd, rs1, rs2, imm, off, r;
    bit hit;
    op = int'(in[6:0]); f3 = int'(in[14:12]); f7 = int'(in[31:25]);
    rd = int'(in[11:7]); rs1 = int'(in[19:15]); rs2 = int'(in[24:20]);
    imm = int'($signed(in[31:20]));
    off = int'($signed({in[31:25], in[11:7]}));
    hit = 1'b1;
    r = 0;
    if (op == 'h13 && f3 == 0 && rs1 == 2 && rd >= 8 && rd <= 15 && imm > 0 && imm < 1024 && imm % 4 == 0)
      r = (((imm >> 4) & 3) << 11) | (((imm >> 6) & 15) << 7) | (((imm >> 2) & 1) << 6) |
          (((imm >> 3) & 1) << 5) | ((rd - 8) << 2);
    else if (op == 'h13 && f3 == 0 && rs1 == 0 && rd != 0 && imm >= -32 && imm <= 31)
      r = 'h4001 | (((imm >> 5) & 1) << 12) | (rd << 7) | ((imm & 31) << 2);
    else if (op == 'h13 && f3 == 0 && rs1 == rd && rd != 0 && imm != 0 && imm >= -32 && imm <= 31)
      r = 'h0001 | (((imm >> 5) & 1) << 12) | (rd << 7) | ((imm & 31) << 2);
`ifdef RV32C_COMPRESS_LDST_EN
    else if (op == 'h03 && f3 == 2 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 && imm >= 0 && imm < 128 && imm % 4 == 0)
      r = 'h4000 | (((imm >> 3) & 7) << 10) | ((rs1 - 8) << 7) | (((imm >> 2) & 1) << 6) |
          (((imm >> 6) & 1) << 5) | ((rd - 8) << 2);
    else if (op == 'h23 && f3 == 2 && rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 && off >= 0 && off < 128 && off % 4 == 0)
      r = 'hC000 | (((off >> 3) & 7) << 10) | ((rs1 - 8) << 7) | (((off >> 2) & 1) << 6) |
          (((off >> 6) & 1) << 5) | ((rs2 - 8) << 2);
`endif
    else if (op == 'h33 && f3 == 0 && f7 == 0 && rs1 == 0 && rd != 0 && rs2 != 0)
      r = 'h8002 | (rd << 7) | (rs2 << 2);
    else if (op == 'h33 && f3 == 0 && f7 == 0 && rs1 == rd && rd != 0 && rs2 != 0)
      r = 'h9002 | (rd << 7) | (rs2 << 2);
    else
      hit = 1'b0;
    c = r[15:0];
    return hit;
  endfunction
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    logic [15:0] c;
    bit rdy_m, acc;
    @(negedge clk);
    iVALID = v; iINSTR = ins; iREADY = rdy; iFLUSH = fl;
    #1;
    rdy_m = wq.size() == 0 || rdy;
    acc = v && rdy_m;
    chk("pending", 32'(oPENDING), 32'(hq.size()));
    chk("saved", 32'(oSAVED), 32'(m_saved));
    chk("ovalid", 32'(oVALID), 32'(wq.size() != 0));
    chk("oready", 32'(oREADY), 32'(rdy_m));
    if (wq.size() != 0 && rdy) chk("word", oWORD, wq.pop_front());
    if (acc) begin
      if (ref_c16(ins, c)) begin
        hq.push_back(c);
        if (m_saved < SAT) m_saved++;
      end else begin
        hq.push_back(ins[15:0]);
        hq.push_back(ins[31:16]);
      end
    end else if (fl && hq.size() == 1 && rdy_m) hq.push_back(16'h0001);
    if (hq.size() >= 2) begin
      wq.push_back({hq[1], hq[0]});
      void'(hq.pop_front());
      void'(hq.pop_front());
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    iRST = 1'b1; iVALID = 1'b1; iINSTR = 32'h00140413; iREADY = 1'b0; iFLUSH = 1'b1;
    @(negedge clk);
    iRST = 1'b0; iVALID = 1'b0; iFLUSH = 1'b0; iREADY = 1'b1;
    hq.delete(); wq.delete(); m_saved = 0;
    #1;
    chk("rst_valid", 32'(oVALID), 32'd0);
    chk("rst_pending", 32'(oPENDING), 32'd0);
    chk("rst_saved", 32'(oSAVED), 32'd0);
    chk("rst_word", oWORD, 32'd0);
  endtask
  function automatic logic [4:0] pick_reg();
    return 5'($urandom_range(0, 1) ? $urandom_range(6, 17) : $urandom_range(0, 31));
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    logic [11:0] imm;
    rd = pick_reg(); rs2 = pick_reg();
    case ($urandom_range(0, 3))
      0: rs1 = 5'd0;
      1: rs1 = 5'd2;
      2: rs1 = rd;
      default: rs1 = pick_reg();
    endcase
    case ($urandom_range(0, 2))
      0: imm = 12'($urandom_range(0, 63)) - 12'd32;
      1: imm = 12'($urandom_range(0, 255) * 4);
      default: imm = 12'($urandom);
    endcase
    case ($urandom_range(0, 6))
      0, 1: return {imm, rs1, 3'b000, rd, 7'h13};
      2: return {($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      3: return {imm, rs1, 3'b010, rd, 7'h03};
      4: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      5: return {20'($urandom), rd, 7'h37};
      default: return {30'($urandom), 2'b11};
    endcase
  endfunction
  initial begin
    do_reset();
    step(1, 32'h01010413, 1, 0);
    step(1, 32'h00140413, 1, 0);
    step(0, 32'd0, 1, 0);
    chk("t1_word", oWORD, 32'h04050800);
    chk("t1_saved", 32'(oSAVED), 32'd2);
    do_reset();
    step(1, 32'h01010413, 1, 0);
    step(1, 32'h123450B7, 1, 0);
    step(0, 32'd0, 0, 0);
    chk("t2_word", oWORD, 32'h50B70800);
    chk("t2_pending", 32'(oPENDING), 32'd1);
    step(0, 32'd0, 1, 1);
    step(0, 32'd0, 0, 0);
    chk("t2_flush_word", oWORD, 32'h00011234);
    chk("t2_flush_pending", 32'(oPENDING), 32'd0);
    step(0, 32'd0, 1, 1);
    do_reset();
    step(1, 32'h00000413, 1, 0);
    step(0, 32'd0, 1, 1);
    step(0, 32'd0, 1, 0);
    chk("t3_li_word", oWORD, 32'h00014401);
    step(1, 32'h00010413, 1, 0);
    step(0, 32'd0, 1, 0);
    chk("t3_pass_word", oWORD, 32'h00010413);
    do_reset();
    step(1, 32'h123450B7, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'hABCDE2B7, 0, 0);
      chk("t4_stable", oWORD, 32'h123450B7);
      chk("t4_blocked", 32'(oREADY), 32'd0);
    end
    step(1, 32'hABCDE2B7, 1, 0);
    step(0, 32'd0, 1, 0);
    chk("t4_reload", oWORD, 32'hABCDE2B7);
    do_reset();
    step(1, 32'h01010413, 0, 0);
    step(1, 32'h123450B7, 0, 0);
    step(0, 32'd0, 0, 0);
    chk("t5_pre_valid", 32'(oVALID), 32'd1);
    chk("t5_pre_pending", 32'(oPENDING), 32'd1);
    do_reset();
    step(1, 32'h00442483, 1, 0);
    step(0, 32'd0, 1, 0);
`ifdef RV32C_COMPRESS_LDST_EN
    chk("t6_lw_saved", 32'(oSAVED), 32'd1);
    step(0, 32'd0, 1, 1);
    step(0, 32'd0, 1, 0);
    chk("t6_lw_word", oWORD, 32'h00014044);
`else
    chk("t6_lw_word", oWORD, 32'h00442483);
`endif
    do_reset();
    for (int i = 0; i < 20; i++) step(1, {7'h00, 5'd3, 5'd0, 3'b000, 5'd4, 7'h33}, 1, 0);
    step(0, 32'd0, 1, 0);
    chk("sat_saved", 32'(oSAVED), 32'(SAT));
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    for (int i = 0; i < 6; i++) step(0, 32'd0, 1, 1);
    chk("drain_pending", 32'(oPENDING), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
